mp_pool_unit: RTL and testbench

Compute stage directly downstream of the max-pool row buffer. Each input word is one pixel holding 4 signed int8 channels. The unit joins the buffered upper-row stream with the live lower-row stream and takes the lane-wise vertical max. It then does the horizontal max in one of two modes:
- 26-wide maps: 2x2 stride-2.
- 13-wide maps: 2x2 stride-1 with right-edge replicate.

Results go out as a valid/ready stream toward the output writer.

---
 rtl/mp_pool_unit_pkg.sv | 21 ++
 rtl/mp_lane_max.sv | 17 +
 rtl/mp_pool_unit.sv | 121 ++++++++++++
 tb/tb_mp_pool_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_pool_unit_pkg.sv
// Shared types and helpers for the max-pool compute stage.
// Lane count, map-width constants, FSM states and the per-lane signed max.
package mp_pool_unit_pkg;

    localparam int LANES    = 4;
    localparam int WIDTH_26 = 26;
    localparam int WIDTH_13 = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Signed int8 max applied to one lane of a packed word.
    function automatic logic [7:0] s8_max(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/mp_lane_max.sv
// Lane-wise signed int8 max of two packed words.
// Purely combinational, zero latency, no flow control.
module mp_lane_max
    import mp_pool_unit_pkg::*;
#(
    parameter int N = LANES
) (
    input  logic [8*N-1:0] i_a,
    input  logic [8*N-1:0] i_b,
    output logic [8*N-1:0] o_max
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign o_max[8*g +: 8] = s8_max(i_a[8*g +: 8], i_b[8*g +: 8]);
    end

endmodule

// File: rtl/mp_pool_unit.sv
// 2x2 max pool (stride-2 on 26-wide rows, stride-1 with edge replicate otherwise), 1-cycle latency.
// Input join stalls whenever the output register holds an unaccepted word.
module mp_pool_unit
    import mp_pool_unit_pkg::*;
#(
    parameter int LANES = mp_pool_unit_pkg::LANES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8:0]           ifm_width,
    input  logic                 start,
    input  logic                 a_valid,
    input  logic [8*LANES-1:0]   a_data,
    input  logic                 b_valid,
    input  logic [8*LANES-1:0]   b_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [8*LANES-1:0]   out_data,
    input  logic                 out_ready,
    output logic                 row_done,
    output logic                 busy
);

    localparam int W = 8 * LANES;

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_col;
    logic [4:0]     r_ncol;
    logic           r_mode_s2;
    logic [W-1:0]   r_hold;
    logic           r_out_vld;
    logic [W-1:0]   r_out_dat;

    logic [W-1:0]   w_vmax;
    logic [W-1:0]   w_hmax;
    logic [W-1:0]   w_h_b;
    logic           w_out_free;
    logic           w_acc;
    logic           w_last;
    logic           w_prod;
    logic           w_flush_ld;

    assign w_out_free = !r_out_vld || out_ready;
    assign w_acc      = a_valid && b_valid && in_ready;
    assign w_last     = (r_col == r_ncol - 5'd1);
    assign w_prod     = w_acc && (r_mode_s2 ? r_col[0] : (r_col != 5'd0));
    assign w_flush_ld = (r_state == FLUSH) && w_out_free;
    // The flush word is the held column against itself, i.e. right-edge replicate.
    assign w_h_b      = (r_state == FLUSH) ? r_hold : w_vmax;

    mp_lane_max #(.N(LANES)) u_vmax (
        .i_a   (a_data),
        .i_b   (b_data),
        .o_max (w_vmax)
    );

    mp_lane_max #(.N(LANES)) u_hmax (
        .i_a   (r_hold),
        .i_b   (w_h_b),
        .o_max (w_hmax)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_acc && w_last) w_next = r_mode_s2 ? DRAIN : FLUSH;
            FLUSH:   if (w_out_free) w_next = DRAIN;
            DRAIN:   if (r_out_vld && out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == RUN) && w_out_free;
        busy     = (r_state != IDLE);
        row_done = (r_state == DRAIN) && r_out_vld && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col     <= 5'd0;
            r_ncol    <= 5'(WIDTH_13);
            r_mode_s2 <= 1'b0;
            r_hold    <= '0;
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_col     <= 5'd0;
                r_mode_s2 <= (ifm_width == 9'(WIDTH_26));
                r_ncol    <= (ifm_width == 9'(WIDTH_26)) ? 5'(WIDTH_26) : 5'(WIDTH_13);
            end
            if (w_acc) begin
                r_col <= w_last ? 5'd0 : r_col + 5'd1;
                if (!r_mode_s2 || !r_col[0]) begin
                    r_hold <= w_vmax;
                end
            end
            if (w_prod || w_flush_ld) begin
                r_out_vld <= 1'b1;
                r_out_dat <= w_hmax;
            end else if (out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;

endmodule

// File: tb/tb_mp_pool_unit.sv
// Randomized directed bench for mp_pool_unit with a row-level reference model.
module tb_mp_pool_unit;

    logic        clk;
    logic        rst_n;
    logic [8:0]  ifm_width;
    logic        start;
    logic        a_valid;
    logic [31:0] a_data;
    logic        b_valid;
    logic [31:0] b_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        row_done;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] ra [26];
    logic [31:0] rb [26];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          busy_cyc;
    int          rd_cnt;

    mp_pool_unit #(.LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifm_width (ifm_width),
        .start     (start),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .row_done  (row_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: each int8 lane compared as a signed number.
    function automatic logic [31:0] m_max(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            if ($signed(x[8*i +: 8]) > $signed(y[8*i +: 8])) r[8*i +: 8] = x[8*i +: 8];
            else r[8*i +: 8] = y[8*i +: 8];
        end
        return r;
    endfunction

    // Pool a whole row pair into the expected output list.
    task automatic build_expected(input int ncol);
        logic [31:0] v [26];
        exp_q.delete();
        for (int k = 0; k < ncol; k++) v[k] = m_max(ra[k], rb[k]);
        if (ncol == 26) begin
            for (int j = 0; j < 13; j++) exp_q.push_back(m_max(v[2*j], v[2*j+1]));
        end else begin
            for (int k = 1; k < 13; k++) exp_q.push_back(m_max(v[k-1], v[k]));
            exp_q.push_back(v[12]);
        end
    endtask

    task automatic fill_rows(input int pat);
        for (int k = 0; k < 26; k++) begin
            case (pat)
                0: begin ra[k] = 32'h01020304; rb[k] = 32'h7F80FF00; end
                1: begin ra[k] = 32'(k);       rb[k] = 32'h0;        end
                2: begin ra[k] = 32'h807F0000; rb[k] = 32'hFF800000; end
                default: begin ra[k] = $urandom; rb[k] = $urandom; end
            endcase
        end
    endtask

    task automatic run_pass(input string tag, input logic [8:0] w, input int pat, input int skew,
                            input int bp_at, input bit rnd, input int rst_col);
        int          ncol;
        int          idx;
        int          cyc;
        bit          held;
        logic [31:0] prev;
        ncol = (w == 9'd26) ? 26 : 13;
        fill_rows(pat);
        build_expected(ncol);
        got_q.delete();
        idx = 0; cyc = 0; held = 0; prev = '0; busy_cyc = 0; rd_cnt = 0;
        forever begin
            @(negedge clk);
            start     = (cyc == 0) || (rnd && $urandom_range(0, 7) == 0);
            ifm_width = (cyc == 0) ? w : 9'($urandom);
            if (idx < ncol) begin
                a_data  = ra[idx];
                b_data  = rb[idx];
                a_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                b_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (cyc < 1 + skew) b_valid = 1'b0;
            end else begin
                a_valid = 1'b0;
                b_valid = 1'b0;
                a_data  = $urandom;
                b_data  = $urandom;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (cyc >= bp_at && cyc < bp_at + 5) out_ready = 1'b0;
            if (rst_col >= 0 && idx == rst_col) rst_n = 1'b0;
            #1;
            if (!rst_n) break;
            if (cyc > 0 && !busy) begin
                start = 1'b0;
                break;
            end
            if (cyc > 0) busy_cyc++;
            if (skew > 0 && cyc == skew) chk({tag, " skew_no_acc"}, 32'(idx), 32'd0);
            if (held) begin
                chk({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
                chk({tag, " hold_data"}, out_data, prev);
            end
            if (out_valid && !out_ready) chk({tag, " bp_in_ready"}, {31'd0, in_ready}, 32'd0);
            held = out_valid && !out_ready;
            prev = out_data;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (row_done) rd_cnt++;
            if (a_valid && b_valid && in_ready) idx++;
            cyc++;
            if (cyc > 3000) begin
                chk({tag, " timeout"}, 32'(cyc), 32'd0);
                break;
            end
        end
        start = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (rst_col >= 0) begin
            @(posedge clk);
            #1;
            chk({tag, " rst_out_valid"}, {31'd0, out_valid}, 32'd0);
            chk({tag, " rst_out_data"}, out_data, 32'd0);
            chk({tag, " rst_in_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, " rst_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, " rst_row_done"}, {31'd0, row_done}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                chk($sformatf("%s word%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp_q[i]);
            chk({tag, " row_done"}, 32'(rd_cnt), 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ifm_width = 9'd26;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset row_done", {31'd0, row_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pass("s2_const", 9'd26, 0, 0, -100, 1'b0, -1);
        chk("s2_const literal", (got_q.size() > 0) ? got_q[0] : 32'h0, 32'h7F020304);
        chk("s2_const cycles", 32'(busy_cyc), 32'd27);

        run_pass("s1_index", 9'd13, 1, 0, -100, 1'b0, -1);
        chk("s1_index cycles", 32'(busy_cyc), 32'd15);
        chk("s1_index last", (got_q.size() == 13) ? got_q[12] : 32'h0, 32'd12);

        run_pass("signed", 9'd13, 2, 0, -100, 1'b0, -1);
        chk("signed literal", (got_q.size() > 0) ? got_q[0] : 32'h0, 32'hFF7F0000);

        run_pass("bp_s2", 9'd26, 3, 0, 8, 1'b0, -1);
        run_pass("bp_s1", 9'd13, 3, 0, 6, 1'b0, -1);
        run_pass("skew", 9'd13, 1, 3, -100, 1'b0, -1);
        run_pass("mid_rst", 9'd26, 3, 0, -100, 1'b0, 7);
        run_pass("after_rst", 9'd26, 3, 0, -100, 1'b0, -1);
        run_pass("w100", 9'd100, 3, 0, -100, 1'b0, -1);

        for (int p = 0; p < 8; p++) begin
            run_pass($sformatf("rnd%0d", p), (p % 2 == 0) ? 9'd26 : 9'($urandom_range(0, 25)),
                     3, $urandom_range(0, 3), $urandom_range(2, 30), 1'b1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
